// File: rtl/pc_sequencer.sv
// Next-PC sequencing FSM: fetch, execute, and single-level interrupt entry.
// Drives the PC register load port and keeps the interrupt return address.
module pc_sequencer #(
    parameter int              PC_W     = 10,
    parameter logic [PC_W-1:0] INTR_VEC = 'h3F0
) (
    input  logic            clk,
    input  logic            RST,
    input  logic [PC_W-1:0] pc_in,
    input  logic            mem_ready,
    input  logic            is_jump,
    input  logic [PC_W-1:0] jump_tgt,
    input  logic            is_branch,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_tgt,
    input  logic            is_mret,
    input  logic            intr,
    input  logic            intr_en,
    output logic [PC_W-1:0] pc_data,
    output logic            pc_ld,
    output logic            fetch_req,
    output logic            intr_ack,
    output logic [PC_W-1:0] mepc,
    output logic            in_isr,
    output logic [1:0]      state
);

    localparam logic [1:0] S_FETCH = 2'b00;
    localparam logic [1:0] S_EXEC  = 2'b01;
    localparam logic [1:0] S_TRAP  = 2'b10;

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] mepc_q, mepc_d;
    logic [PC_W-1:0] saved_q, saved_d;
    logic            isr_q, isr_d;
    logic [PC_W-1:0] next_pc;
    logic [PC_W-1:0] tgt;
    logic            trap;

    assign next_pc = pc_in + {{(PC_W-1){1'b0}}, 1'b1};
    // mret is never preempted, so a trap always saves a non-mret target
    assign trap    = intr & intr_en & ~isr_q & ~is_mret;

    always_comb begin
        tgt = next_pc;
        if (is_mret)
            tgt = mepc_q;
        else if (is_jump)
            tgt = jump_tgt;
        else if (is_branch && br_taken)
            tgt = br_tgt;
    end

    always_comb begin
        state_d   = S_FETCH;
        mepc_d    = mepc_q;
        saved_d   = saved_q;
        isr_d     = isr_q;
        pc_data   = tgt;
        pc_ld     = 1'b0;
        fetch_req = 1'b0;
        intr_ack  = 1'b0;
        case (state_q)
            S_FETCH: begin
                fetch_req = 1'b1;
                state_d   = mem_ready ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
                if (trap) begin
                    saved_d = tgt;
                    state_d = S_TRAP;
                end else begin
                    pc_ld = ~RST;
                    if (is_mret)
                        isr_d = 1'b0;
                end
            end
            S_TRAP: begin
                pc_data  = INTR_VEC;
                pc_ld    = ~RST;
                intr_ack = ~RST;
                mepc_d   = saved_q;
                isr_d    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= S_FETCH;
            mepc_q  <= '0;
            saved_q <= '0;
            isr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mepc_q  <= mepc_d;
            saved_q <= saved_d;
            isr_q   <= isr_d;
        end
    end

    assign mepc   = mepc_q;
    assign in_isr = isr_q;
    assign state  = state_q;

endmodule
